// File: rtl/core_step_ctrl_pkg.sv
// Shared types and constants for the core run/step sequencer.
package core_ctrl_pkg;

    typedef enum logic [2:0] {
        HALT,
        RUN,
        STEP_A,
        STEP_B,
        DRAIN
    } state_t;

    localparam logic [1:0] MODE_HALT = 2'b00;
    localparam logic [1:0] MODE_RUN  = 2'b01;
    localparam logic [1:0] MODE_TICK = 2'b10;

    // 2'b11 is deliberately treated like MODE_HALT.
    function automatic logic is_run_mode(input logic [1:0] mode);
        return (mode == MODE_RUN) || (mode == MODE_TICK);
    endfunction

endpackage

// File: rtl/core_step_ctrl_if.sv
// Control/status bundle between board controls, divider, core and the sequencer.
// Breakpoint signals exist only when CORE_STEP_BREAKPOINT_EN is defined.
interface core_step_ctrl_if #(
    parameter int CNT_W = 16,
    parameter int PC_W  = 32
);
    logic [1:0]       mode_i;
    logic             step_i;
    logic             tick_i;
    logic             fetch_i;
    logic             cnt_clr_i;
    logic             core_en_o;
    logic             halted_o;
    logic [CNT_W-1:0] instr_cnt_o;

`ifdef CORE_STEP_BREAKPOINT_EN
    logic             bp_en_i;
    logic [PC_W-1:0]  bp_addr_i;
    logic [PC_W-1:0]  pc_i;
    logic             bp_hit_o;

    modport master (
        output mode_i, step_i, tick_i, fetch_i, cnt_clr_i, bp_en_i, bp_addr_i, pc_i,
        input  core_en_o, halted_o, instr_cnt_o, bp_hit_o
    );

    modport slave (
        input  mode_i, step_i, tick_i, fetch_i, cnt_clr_i, bp_en_i, bp_addr_i, pc_i,
        output core_en_o, halted_o, instr_cnt_o, bp_hit_o
    );
`else
    localparam int unused_pc_w = PC_W;

    modport master (
        output mode_i, step_i, tick_i, fetch_i, cnt_clr_i,
        input  core_en_o, halted_o, instr_cnt_o
    );

    modport slave (
        input  mode_i, step_i, tick_i, fetch_i, cnt_clr_i,
        output core_en_o, halted_o, instr_cnt_o
    );
`endif

endinterface

// File: rtl/core_step_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/core_step_ctrl.sv
// Run/step sequencer for the multicycle core: gates core_en so halts land on FETCH.
// Optional breakpoint compare enabled by defining CORE_STEP_BREAKPOINT_EN.
module core_step_ctrl
    import core_ctrl_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int PC_W  = 32
) (
    input logic             clk,
    input logic             rst,
    core_step_ctrl_if.slave bus
);

    state_t           state;
    state_t           state_nxt;
    logic             pace;
    logic             run_mode;
    logic             core_en;
    logic             halted;
    logic             bp_stop;
    logic             halt_exit;
    logic [CNT_W-1:0] count;

    assign pace      = (bus.mode_i == MODE_TICK) ? bus.tick_i : 1'b1;
    assign run_mode  = is_run_mode(bus.mode_i);
    assign halt_exit = (state == HALT) && (state_nxt != HALT);

`ifdef CORE_STEP_BREAKPOINT_EN
    logic skip;
    logic bp_hit;

    // skip masks the compare until the first fetch after a resume has executed.
    assign bp_stop = pace & bus.fetch_i & bus.bp_en_i & (bus.pc_i == bus.bp_addr_i) & ~skip;

    always_ff @(posedge clk) begin
        if (rst) begin
            skip   <= 1'b0;
            bp_hit <= 1'b0;
        end else begin
            if (halt_exit) begin
                skip <= 1'b1;
            end else if (core_en && bus.fetch_i) begin
                skip <= 1'b0;
            end
            if (halt_exit) begin
                bp_hit <= 1'b0;
            end else if ((state == RUN) && run_mode && bp_stop) begin
                bp_hit <= 1'b1;
            end
        end
    end

    assign bus.bp_hit_o = bp_hit;
`else
    localparam int unused_pc_w = PC_W;
    assign bp_stop = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= HALT;
            halted <= 1'b1;
        end else begin
            state  <= state_nxt;
            halted <= (state_nxt == HALT);
        end
    end

    always_comb begin
        state_nxt = state;
        core_en   = 1'b0;
        unique case (state)
            HALT: begin
                if (run_mode) begin
                    state_nxt = RUN;
                end else if (bus.step_i) begin
                    state_nxt = STEP_A;
                end
            end
            RUN: begin
                if (!run_mode) begin
                    // Already parked on FETCH: stop without executing it.
                    if (bus.fetch_i) begin
                        state_nxt = HALT;
                    end else begin
                        core_en   = pace;
                        state_nxt = DRAIN;
                    end
                end else if (bp_stop) begin
                    state_nxt = HALT;
                end else begin
                    core_en = pace;
                end
            end
            STEP_A: begin
                core_en   = 1'b1;
                state_nxt = STEP_B;
            end
            STEP_B: begin
                if (bus.fetch_i) begin
                    state_nxt = HALT;
                end else begin
                    core_en = 1'b1;
                end
            end
            DRAIN: begin
                core_en = pace & ~bus.fetch_i;
                if (run_mode) begin
                    state_nxt = RUN;
                end else if (bus.fetch_i) begin
                    state_nxt = HALT;
                end
            end
            default: begin
                state_nxt = HALT;
            end
        endcase
    end

    sat_counter #(.CNT_W(CNT_W)) u_instr_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (bus.cnt_clr_i),
        .inc   (core_en & bus.fetch_i),
        .count (count)
    );

    assign bus.core_en_o   = core_en;
    assign bus.halted_o    = halted;
    assign bus.instr_cnt_o = count;

endmodule

// File: tb/tb_core_step_ctrl.sv
// Directed scoreboard bench for core_step_ctrl driving a 4-cycle fake core.
module tb_core_step_ctrl;
    import core_ctrl_pkg::*;

    localparam int CNT_W = 4;
    localparam int PC_W  = 32;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  phase;
    logic [31:0] pc;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   en_cnt = 0;
    int   cyc_n  = 0;
    bit   tick_on = 1'b0;

    core_step_ctrl_if #(.CNT_W(CNT_W), .PC_W(PC_W)) bus ();

    core_step_ctrl #(.CNT_W(CNT_W), .PC_W(PC_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Fake core: FETCH every 4 enabled cycles, PC advances 4 per executed fetch.
    always @(posedge clk) begin
        if (rst) begin
            phase <= 2'd0;
            pc    <= 32'd0;
        end else if (bus.core_en_o) begin
            phase <= phase + 2'd1;
            if (phase == 2'd0) pc <= pc + 32'd4;
        end
    end

    assign bus.fetch_i = (phase == 2'd0);
`ifdef CORE_STEP_BREAKPOINT_EN
    assign bus.pc_i = pc;
`endif

    always @(posedge clk) begin
        if (bus.core_en_o === 1'b1) en_cnt <= en_cnt + 1;
    end

    task automatic expect_val(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_underflow observed %0h expected none", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s observed %0h expected %0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        cyc_n++;
        bus.tick_i = tick_on && (cyc_n % 8 == 0);
    endtask

    task automatic look();
        #2;
    endtask

    task automatic wait_halt(input int maxc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < maxc && !ok; i++) begin
            cycle();
            ok = (bus.halted_o === 1'b1);
        end
    endtask

    initial begin
        int  base;
        int  mism;
        int  f0;
        int  gap;
        bit  ok;
        bit  all_en;
        logic en_now;

        rst           = 1'b1;
        bus.mode_i    = MODE_HALT;
        bus.step_i    = 1'b0;
        bus.tick_i    = 1'b0;
        bus.cnt_clr_i = 1'b0;
`ifdef CORE_STEP_BREAKPOINT_EN
        bus.bp_en_i   = 1'b0;
        bus.bp_addr_i = '0;
`endif

        // Reset
        expect_val("reset_halted", 1);
        expect_val("reset_core_en", 0);
        expect_val("reset_cnt", 0);
        repeat (3) cycle();
        look();
        check(bus.halted_o);
        check(bus.core_en_o);
        check(bus.instr_cnt_o);
        rst = 1'b0;
        cycle();

        // Single step: 4 enabled cycles, lands back on FETCH
        expect_val("step_enables", 4);
        expect_val("step_halted", 1);
        expect_val("step_fetch", 1);
        expect_val("step_cnt", 1);
        expect_val("step_done", 1);
        base = en_cnt;
        bus.step_i = 1'b1;
        cycle();
        bus.step_i = 1'b0;
        wait_halt(20, ok);
        repeat (3) cycle();
        check(en_cnt - base);
        check(bus.halted_o);
        check(bus.fetch_i);
        check(bus.instr_cnt_o);
        check(ok);

        bus.cnt_clr_i = 1'b1;
        cycle();
        bus.cnt_clr_i = 1'b0;

        // Free run for 20 cycles
        expect_val("run_enables", 20);
        expect_val("run_all_en", 1);
        expect_val("run_cnt", 5);
        bus.mode_i = MODE_RUN;
        cycle();
        base = en_cnt;
        all_en = 1'b1;
        repeat (20) begin
            look();
            if (bus.core_en_o !== 1'b1) all_en = 1'b0;
            cycle();
        end
        check(en_cnt - base);
        check(all_en);
        check(bus.instr_cnt_o);

        // Halt mid-instruction: drain to FETCH
        expect_val("drain_enables", 2);
        expect_val("drain_halted", 1);
        expect_val("drain_fetch", 1);
        expect_val("drain_cnt", 6);
        expect_val("drain_done", 1);
        repeat (2) cycle();
        bus.mode_i = MODE_HALT;
        base = en_cnt;
        wait_halt(20, ok);
        repeat (2) cycle();
        check(en_cnt - base);
        check(bus.halted_o);
        check(bus.fetch_i);
        check(bus.instr_cnt_o);
        check(ok);

        bus.cnt_clr_i = 1'b1;
        cycle();
        bus.cnt_clr_i = 1'b0;

        // Tick-paced run
        expect_val("tick_en_mismatches", 0);
        expect_val("tick_enables", 8);
        expect_val("tick_fetch_gap", 32);
        expect_val("tick_cnt", 2);
        expect_val("tick_stop_core_en", 0);
        expect_val("tick_stop_halted", 1);
        tick_on = 1'b1;
        bus.mode_i = MODE_TICK;
        cycle();
        base = en_cnt;
        mism = 0;
        f0 = -1;
        gap = 0;
        repeat (64) begin
            look();
            if (bus.core_en_o !== bus.tick_i) mism++;
            if (bus.core_en_o === 1'b1 && bus.fetch_i === 1'b1) begin
                if (f0 < 0) f0 = cyc_n;
                else if (gap == 0) gap = cyc_n - f0;
            end
            cycle();
        end
        tick_on = 1'b0;
        bus.tick_i = 1'b0;
        bus.mode_i = MODE_HALT;
        look();
        en_now = bus.core_en_o;
        cycle();
        check(mism);
        check(en_cnt - base);
        check(gap);
        check(bus.instr_cnt_o);
        check(en_now);
        check(bus.halted_o);

        // Mode wins over simultaneous step; step ignored in RUN
        expect_val("simul_halted", 0);
        expect_val("simul_enables", 10);
        expect_val("simul_stop_done", 1);
        bus.step_i = 1'b1;
        bus.mode_i = MODE_RUN;
        cycle();
        bus.step_i = 1'b0;
        base = en_cnt;
        for (int i = 0; i < 10; i++) begin
            if (i == 3) bus.step_i = 1'b1;
            if (i == 4) bus.step_i = 1'b0;
            cycle();
        end
        check(bus.halted_o);
        check(en_cnt - base);
        bus.mode_i = MODE_HALT;
        wait_halt(20, ok);
        check(ok);

        // Reset in the middle of a run
        expect_val("rstrun_halted", 1);
        expect_val("rstrun_cnt", 0);
        expect_val("rstrun_core_en", 0);
        bus.mode_i = MODE_RUN;
        repeat (6) cycle();
        rst = 1'b1;
        bus.mode_i = MODE_HALT;
        cycle();
        rst = 1'b0;
        look();
        check(bus.halted_o);
        check(bus.instr_cnt_o);
        check(bus.core_en_o);

`ifdef CORE_STEP_BREAKPOINT_EN
        // Breakpoint at 0x10, then resume past it
        expect_val("bp_done", 1);
        expect_val("bp_enables", 16);
        expect_val("bp_halted", 1);
        expect_val("bp_hit", 1);
        expect_val("bp_pc", 32'h10);
        expect_val("bp_cnt", 4);
        expect_val("resume_halted", 0);
        expect_val("resume_hit", 0);
        expect_val("resume_pc", 32'h18);
        expect_val("resume_stop_done", 1);
        bus.bp_en_i   = 1'b1;
        bus.bp_addr_i = 32'h10;
        bus.mode_i    = MODE_RUN;
        cycle();
        base = en_cnt;
        wait_halt(60, ok);
        bus.mode_i = MODE_HALT;
        check(ok);
        check(en_cnt - base);
        check(bus.halted_o);
        check(bus.bp_hit_o);
        check(pc);
        check(bus.instr_cnt_o);
        bus.mode_i = MODE_RUN;
        cycle();
        repeat (8) cycle();
        check(bus.halted_o);
        check(bus.bp_hit_o);
        check(pc);
        bus.mode_i  = MODE_HALT;
        bus.bp_en_i = 1'b0;
        wait_halt(20, ok);
        check(ok);
`endif

        // Saturation at 15, clear beats a simultaneous fetch
        expect_val("sat_cnt", 15);
        expect_val("clr_with_fetch_cnt", 0);
        expect_val("after_clr_cnt", 1);
        expect_val("sat_stop_done", 1);
        bus.cnt_clr_i = 1'b1;
        cycle();
        bus.cnt_clr_i = 1'b0;
        bus.mode_i = MODE_RUN;
        cycle();
        repeat (80) cycle();
        check(bus.instr_cnt_o);
        bus.cnt_clr_i = 1'b1;
        cycle();
        bus.cnt_clr_i = 1'b0;
        check(bus.instr_cnt_o);
        repeat (4) cycle();
        check(bus.instr_cnt_o);
        bus.mode_i = MODE_HALT;
        wait_halt(20, ok);
        check(ok);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
